// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the call scheduler, the call panel and the car controller.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] call_buttons;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  car_arrived;
    logic                  target_ready;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  busy;

    modport master (
        input  call_buttons, car_floor, car_arrived, target_ready,
        output target_floor, target_valid, pending, dir_up, busy
    );
    modport slave (
        output call_buttons, car_floor, car_arrived, target_ready,
        input  target_floor, target_valid, pending, dir_up, busy
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// LOOK-policy floor-call scheduler: accumulates calls, picks the next stop,
// offers it to the car over valid/ready and clears calls on arrival.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                      clk,
    input  logic                      reset,
    elevator_call_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_ARRIVE} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] pending_q, pending_nxt, clr;
    logic [NUM_FLOORS-1:0] seen_q, seen_nxt;
    logic [NUM_FLOORS-1:0] between;
    logic [FLOOR_W-1:0]    target_q, target_nxt;
    logic [FLOOR_W-1:0]    lo_above, hi_below;
    logic                  has_above, has_below;
    logic                  valid_q, valid_nxt;
    logic                  dir_q, dir_nxt;
    logic                  busy_q;

    // An arrival clears its floor even if the same floor is being called.
    always_comb begin
        clr = '0;
        if (bus.car_arrived) clr[bus.car_floor] = 1'b1;
        pending_nxt = (pending_q | bus.call_buttons) & ~clr;
    end

    // Nearest-call priority encoders plus the open span toward the current target.
    always_comb begin
        has_above = 1'b0;
        lo_above  = '0;
        has_below = 1'b0;
        hi_below  = '0;
        between   = '0;
        for (int i = NUM_FLOORS-1; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(bus.car_floor))) begin
                has_above = 1'b1;
                lo_above  = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i < int'(bus.car_floor))) begin
                has_below = 1'b1;
                hi_below  = FLOOR_W'(i);
            end
            if (dir_q)
                between[i] = (i > int'(bus.car_floor)) && (i < int'(target_q));
            else
                between[i] = (i < int'(bus.car_floor)) && (i > int'(target_q));
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target_q;
        valid_nxt  = valid_q;
        dir_nxt    = dir_q;
        seen_nxt   = seen_q;
        case (state)
            IDLE: begin
                if (pending_q != '0) state_nxt = SELECT;
            end
            SELECT: begin
                seen_nxt  = pending_q;
                state_nxt = ISSUE;
                valid_nxt = 1'b1;
                if (pending_q[bus.car_floor]) begin
                    target_nxt = bus.car_floor;
                end else if (dir_q && has_above) begin
                    target_nxt = lo_above;
                end else if (!dir_q && has_below) begin
                    target_nxt = hi_below;
                end else if (dir_q && has_below) begin
                    dir_nxt    = 1'b0;
                    target_nxt = hi_below;
                end else if (!dir_q && has_above) begin
                    dir_nxt    = 1'b1;
                    target_nxt = lo_above;
                end else begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            ISSUE: begin
                if (bus.target_ready) begin
                    state_nxt = WAIT_ARRIVE;
                    valid_nxt = 1'b0;
                end
            end
            WAIT_ARRIVE: begin
                // Only calls that appeared since the last pick may pull the car short.
                if (bus.car_arrived && (bus.car_floor == target_q))
                    state_nxt = (pending_nxt != '0) ? SELECT : IDLE;
                else if ((pending_q & ~seen_q & between) != '0)
                    state_nxt = SELECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            seen_q    <= '0;
            target_q  <= '0;
            valid_q   <= 1'b0;
            dir_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending_q <= pending_nxt;
            seen_q    <= seen_nxt;
            target_q  <= target_nxt;
            valid_q   <= valid_nxt;
            dir_q     <= dir_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_q;
    assign bus.target_valid = valid_q;
    assign bus.dir_up       = dir_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request scheduler that sits in front of the `elevator` car controller. It latches floor-call pulses into a pending-call register and selects the next stop with a LOOK policy: continue in the current direction while calls remain ahead, then reverse. It issues each stop to the car over a valid/ready handshake and clears calls as the car reports arrival. It owns direction policy; the car controller owns motion and doors.

## Interface
- `NUM_FLOORS`, default 16: number of floors and the width of the call vector.
- `FLOOR_W`, default 4: floor index width, equal to clog2(`NUM_FLOORS`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `call_buttons`  in  NUM_FLOORS  call pulses; bit i requests floor i; level or pulse, OR-accumulated.
- `car_floor`  in  FLOOR_W  car's current floor.
- `car_arrived`  in  1  1-cycle pulse: car has stopped at `car_floor` with doors opening.
- `target_ready`  in  1  car accepts `target_floor` this cycle.
- `target_floor`  out  FLOOR_W  next stop, registered.
- `target_valid`  out  1  `target_floor` is offered.
- `pending`  out  NUM_FLOORS  outstanding calls, registered.
- `dir_up`  out  1  LOOK direction: 1 = up, 0 = down.
- `busy`  out  1  state is not IDLE.

## Operation
- Pending register: `pending <= (pending | call_buttons) & ~clr`.
  - `clr` = one-hot of `car_floor` when `car_arrived`=1, else 0.
  - When a call and an arrival hit the same floor in the same cycle, clear wins.
  - Arrival clears `pending[car_floor]` in every state.
- States: IDLE, SELECT, ISSUE, WAIT_ARRIVE.
- IDLE → SELECT when `pending` != 0.
- SELECT, one cycle. Evaluated in this order against `car_floor`:
  1. If `pending[car_floor]` is set, target = `car_floor`.
  2. Else, moving up: if any call is above, target = the lowest call above. Moving down: if any call is below, target = the highest call below.
  3. Else, if any call exists in the opposite direction, toggle `dir_up` and target = the nearest call in that direction.
  4. Else (pending is empty), → IDLE.
  - When a target is chosen, register `target_floor` → ISSUE.
- ISSUE:
  - Hold `target_valid`=1 with `target_floor` stable until `target_ready`=1.
  - On the handshake cycle, → WAIT_ARRIVE and drop `target_valid` next cycle.
- WAIT_ARRIVE:
  - `car_arrived` with `car_floor`==`target_floor` → SELECT, or IDLE if pending becomes empty.
  - Retarget: if a pending call lies strictly between `car_floor` and `target_floor` in the current direction, and it was not pending at the previous evaluation, → SELECT. This produces a new handshake with the nearer floor. The old target stays pending.
  - `car_arrived` at any other floor only clears that floor's bit; the state is unchanged.
- `target_floor` changes only in SELECT. `target_valid` never deasserts without a handshake except on reset.

## Timing
- Reset values, applied immediately on `reset`: `pending`=0, `target_floor`=0, `target_valid`=0, `dir_up`=1, `busy`=0, state IDLE. An in-flight target is dropped.
- A call at edge t is visible in `pending` after t+1.
- From IDLE: call at edge t → SELECT at t+2 → `target_valid`=1 at t+3. Worst-case latency is 3 cycles.
- After an arrival: SELECT next cycle, `target_valid` the cycle after (2 cycles).
- All outputs are registered; there are no combinational input-to-output paths.
- Nearest-call search is a priority encode over `NUM_FLOORS` bits and completes in a single SELECT cycle.

## Test plan
- **Basic call:** reset, `car_floor`=0, pulse `call_buttons`=16'h0008 → `pending`=16'h0008 next cycle; `target_valid`=1 with `target_floor`=3 and `dir_up`=1 within 3 cycles. Then `target_ready`=1 → valid drops; `car_arrived` at 3 → `pending`=0 and `busy`=0 within 2 cycles.
- **LOOK ordering:** `car_floor`=5, `dir_up`=1, pending floors {2,7,9}, each serviced by ready+arrive → targets issued 7, 9, 2 in that order. `dir_up` goes to 0 in the SELECT that picks 2.
- **Retarget:** target 9 accepted, `car_floor`=2; call floor 4 → new handshake with `target_floor`=4. After arrival at 4, the next target is 9 and bit 9 stays set throughout.
- **Current floor and collision:**
  - Idle at `car_floor`=6, call 6 → `target_floor`=6 issued.
  - In a separate cycle, assert call 6 together with `car_arrived` at 6 → `pending[6]`=0.
- **Backpressure:** hold `target_ready`=0 for 10 cycles with new calls 1 and 12 arriving → `target_valid`=1 and `target_floor` unchanged for all 10 cycles; `pending` accumulates 1 and 12.
- **Reset mid-operation:** assert `reset` asynchronously in WAIT_ARRIVE and ISSUE → all outputs at their reset values before the next clock edge. After release, a new call is scheduled normally.
